// File: rtl/if_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: datapath widths,
// RISC-V opcode constants, FSM state encoding, the packet handed to issue,
// and the BHT saturating-counter step function.
package if_fetch_pkg;

    localparam int unsigned REG_DAT_W = 32;
    localparam int unsigned INS_DAT_W = 32;

    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // Weakly not taken.
    localparam logic [1:0] BHT_INIT = 2'b01;

    typedef enum logic [1:0] {
        ST_REQ,
        ST_WAIT,
        ST_HOLD
    } fetch_state_t;

    typedef struct packed {
        logic [INS_DAT_W-1:0] ins;
        logic                 bj;
        logic [REG_DAT_W-1:0] pc;
        logic [REG_DAT_W-1:0] pjt;
    } is_pkt_t;

    function automatic logic [1:0] bht_next(input logic [1:0] ctr, input logic tk);
        if (tk) begin
            return (ctr == 2'b11) ? ctr : ctr + 2'd1;
        end
        return (ctr == 2'b00) ? ctr : ctr - 2'd1;
    endfunction

endpackage

// File: rtl/if_bht.sv
// Branch history table: 2^IDX_W two-bit saturating counters.
// Ports:
//   clk, rst, en : clock, synchronous active-high reset, global ready
//   rd_idx       : lookup index (from fetch PC)
//   rd_tk        : predicted taken (counter MSB), combinational
//   wr_en        : train enable (committed conditional branch)
//   wr_idx       : index of the committed branch
//   wr_tk        : actual outcome, 1 = taken
// A lookup and a training write to the same index in one cycle sees the
// pre-update counter value.
module if_bht
    import if_fetch_pkg::*;
#(
    parameter int unsigned IDX_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_tk,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_tk
);

    localparam int unsigned DEPTH = 1 << IDX_W;

    logic [1:0] ctr [DEPTH];

    assign rd_tk = ctr[rd_idx][1];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ctr[IDX_W'(i)] <= BHT_INIT;
            end
        end else if (en && wr_en) begin
            ctr[wr_idx] <= bht_next(ctr[wr_idx], wr_tk);
        end
    end

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch stage. Owns the PC, issues one word request at a time
// to the memory controller, predicts the next PC from the returned word
// (JAL always taken, conditional branches via the BHT), and hands one
// instruction per oIS_En pulse to issue. The ROB redirects on mispredict
// (iROB_Flush) and trains the BHT on commit.
// Ports:
//   clk, rst, en      : clock, synchronous active-high reset, global ready
//   oMC_En/oMC_Addr   : fetch request, held with stable address until iMC_Done
//   iMC_Done/iMC_Ins  : response pulse and fetched instruction
//   iROB_Full         : issue cannot accept this cycle
//   iROB_Flush/Pc     : redirect pulse and target
//   iROB_BhtEn/Pc/Tk  : BHT training from committed conditional branches
//   oIS_En/Ins/Bj/Pc/Pjt : instruction to issue, prediction and next PC
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [REG_DAT_W-1:0] RESET_PC  = 32'h0,
    parameter int unsigned          BHT_IDX_W = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    output logic                 oMC_En,
    output logic [REG_DAT_W-1:0] oMC_Addr,
    input  logic                 iMC_Done,
    input  logic [INS_DAT_W-1:0] iMC_Ins,
    input  logic                 iROB_Full,
    input  logic                 iROB_Flush,
    input  logic [REG_DAT_W-1:0] iROB_Pc,
    input  logic                 iROB_BhtEn,
    input  logic [REG_DAT_W-1:0] iROB_BhtPc,
    input  logic                 iROB_BhtTk,
    output logic                 oIS_En,
    output logic [INS_DAT_W-1:0] oIS_Ins,
    output logic                 oIS_Bj,
    output logic [REG_DAT_W-1:0] oIS_Pc,
    output logic [REG_DAT_W-1:0] oIS_Pjt
);

    fetch_state_t         state;
    logic [REG_DAT_W-1:0] pc;
    logic                 flush_pend;
    is_pkt_t              hold;
    is_pkt_t              out_pkt;

    logic                 bht_tk;
    logic [REG_DAT_W-1:0] imm_j;
    logic [REG_DAT_W-1:0] imm_b;
    logic [REG_DAT_W-1:0] pc_seq;
    is_pkt_t              pred;

    // Only the index bits of the training PC reach the table.
    logic unused_bht_pc;
    assign unused_bht_pc = ^{iROB_BhtPc[REG_DAT_W-1:BHT_IDX_W+2], iROB_BhtPc[1:0]};

    if_bht #(
        .IDX_W (BHT_IDX_W)
    ) u_bht (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .rd_idx (pc[BHT_IDX_W+1:2]),
        .rd_tk  (bht_tk),
        .wr_en  (iROB_BhtEn),
        .wr_idx (iROB_BhtPc[BHT_IDX_W+1:2]),
        .wr_tk  (iROB_BhtTk)
    );

    // pc equals the outstanding request address while in WAIT, so the
    // prediction is formed against the PC of the returned word.
    always_comb begin
        imm_j = {{11{iMC_Ins[31]}}, iMC_Ins[31], iMC_Ins[19:12], iMC_Ins[20],
                 iMC_Ins[30:21], 1'b0};
        imm_b = {{19{iMC_Ins[31]}}, iMC_Ins[31], iMC_Ins[7], iMC_Ins[30:25],
                 iMC_Ins[11:8], 1'b0};
        pc_seq   = pc + REG_DAT_W'(4);
        pred.ins = iMC_Ins;
        pred.pc  = pc;
        pred.bj  = 1'b0;
        pred.pjt = pc_seq;
        case (iMC_Ins[6:0])
            OPC_JAL: begin
                pred.bj  = 1'b1;
                pred.pjt = pc + imm_j;
            end
            OPC_BRANCH: begin
                pred.bj  = bht_tk;
                pred.pjt = bht_tk ? pc + imm_b : pc_seq;
            end
            OPC_JALR: begin
                pred.bj  = 1'b0;
                pred.pjt = pc_seq;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_REQ;
            pc         <= RESET_PC;
            flush_pend <= 1'b0;
            oMC_En     <= 1'b0;
            oMC_Addr   <= '0;
            oIS_En     <= 1'b0;
            hold       <= '0;
            out_pkt    <= '0;
        end else if (en) begin
            oIS_En <= 1'b0;
            if (iROB_Flush) begin
                pc <= iROB_Pc;
                if (state == ST_WAIT && !iMC_Done) begin
                    // A bus transaction is never aborted: keep the request
                    // up and throw its response away when it arrives.
                    flush_pend <= 1'b1;
                end else begin
                    flush_pend <= 1'b0;
                    oMC_En     <= 1'b0;
                    state      <= ST_REQ;
                end
            end else begin
                case (state)
                    ST_REQ: begin
                        oMC_En   <= 1'b1;
                        oMC_Addr <= pc;
                        state    <= ST_WAIT;
                    end
                    ST_WAIT: begin
                        if (iMC_Done) begin
                            oMC_En <= 1'b0;
                            if (flush_pend) begin
                                flush_pend <= 1'b0;
                                state      <= ST_REQ;
                            end else if (!iROB_Full) begin
                                oIS_En  <= 1'b1;
                                out_pkt <= pred;
                                pc      <= pred.pjt;
                                state   <= ST_REQ;
                            end else begin
                                hold  <= pred;
                                state <= ST_HOLD;
                            end
                        end
                    end
                    ST_HOLD: begin
                        if (!iROB_Full) begin
                            oIS_En  <= 1'b1;
                            out_pkt <= hold;
                            pc      <= hold.pjt;
                            state   <= ST_REQ;
                        end
                    end
                    default: state <= ST_REQ;
                endcase
            end
        end
    end

    assign oIS_Ins = out_pkt.ins;
    assign oIS_Bj  = out_pkt.bj;
    assign oIS_Pc  = out_pkt.pc;
    assign oIS_Pjt = out_pkt.pjt;

endmodule
